fp_add_share_arbiter: RTL and testbench

//  Shares one combinational FP32 adder among N_REQ requesters (neuron accumulators, bias add).

---
 rtl/fp_add_share_arbiter.sv | 106 ++++++++++
 tb/tb_fp_add_share_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_share_arbiter.sv
// Round-robin share of one combinational FP32 adder among N_REQ requesters.
// The winner's sum is captured in a one-deep response slot tagged with its ID.
module fp_add_share_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ*32-1:0]   req_op1,
  input  logic [N_REQ*32-1:0]   req_op2,
  output logic [N_REQ-1:0]      req_ready,
  output logic [31:0]           add_op1,
  output logic [31:0]           add_op2,
  input  logic [31:0]           add_result,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [31:0]           rsp_data,
  output logic [CNT_W-1:0]      op_count
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  op_count_q, op_count_d;

  logic              found;
  logic [ID_W-1:0]   win;
  logic [ID_W-1:0]   cand;
  logic              can_issue;
  logic              accept;

  // Search starts at rr_ptr and wraps; first valid requester wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = ID_W'((int'(rr_ptr_q) + k) % N_REQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    add_op1 = 32'h0;
    add_op2 = 32'h0;
    for (int i = 0; i < N_REQ; i++) begin
      if (found && (win == ID_W'(i))) begin
        add_op1 = req_op1[32*i +: 32];
        add_op2 = req_op2[32*i +: 32];
      end
    end
  end

  // The slot can take a new result when empty or being drained this cycle.
  assign can_issue = (state_q == EMPTY) || rsp_ready;
  assign accept    = found && can_issue;
  assign req_ready = accept ? (N_REQ'(1) << win) : '0;

  always_comb begin
    state_d    = state_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    rr_ptr_d   = rr_ptr_q;
    op_count_d = op_count_q;
    if (accept) begin
      state_d    = FULL;
      rsp_data_d = add_result;
      rsp_id_d   = win;
      rr_ptr_d   = (win == ID_W'(N_REQ - 1)) ? '0 : win + ID_W'(1);
      op_count_d = op_count_q + CNT_W'(1);
    end else if ((state_q == FULL) && rsp_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      rsp_data_q <= 32'h0;
      rsp_id_q   <= '0;
      rr_ptr_q   <= '0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
      rr_ptr_q   <= rr_ptr_d;
      op_count_q <= op_count_d;
    end
  end

  assign rsp_valid = (state_q == FULL);
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_fp_add_share_arbiter.sv
// Bench for fp_add_share_arbiter: reference arbitration model feeds a response
// scoreboard; a free-running monitor checks every consumed response.
module tb_fp_add_share_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [127:0] req_op1, req_op2;
  logic [3:0]   req_ready;
  logic [31:0]  add_op1, add_op2, add_result;
  logic         rsp_valid, rsp_ready;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_data;
  logic [15:0]  op_count;

  always #5 clk = ~clk;

  // FP32 <-> real for normal operands; zero/denormal inputs read as 0.
  function automatic real f2r(input logic [31:0] f);
    logic [10:0] e;
    if (f[30:23] == 8'h0) return 0.0;
    e = {3'b0, f[30:23]} + 11'd896;
    return $bitstoreal({f[31], e, f[22:0], 29'b0});
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] b;
    int          e;
    b = $realtobits(r);
    if (b[62:0] == 63'h0) return 32'h0;
    e = int'(b[62:52]) - 1023 + 127;
    return {b[63], 8'(e), b[51:29]};
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) + f2r(b));
  endfunction

  // Stand-in for the shared adder instance.
  assign add_result = fadd(add_op1, add_op2);

  fp_add_share_arbiter #(.N_REQ(4), .ID_W(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_op1(req_op1), .req_op2(req_op2), .req_ready(req_ready),
    .add_op1(add_op1), .add_op2(add_op2), .add_result(add_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .op_count(op_count)
  );

  typedef struct {
    logic [1:0]  id;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  bit   m_full = 0;
  int   m_ptr  = 0;
  int   m_cnt  = 0;
  int   last_gnt = -1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rnd_f();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 23'($urandom)};
  endfunction

  function automatic logic [127:0] bcast(input logic [31:0] x);
    return {x, x, x, x};
  endfunction

  // One cycle: drive after the edge, check against the model before the next edge.
  task automatic step(input logic [3:0] v, input logic [127:0] o1, input logic [127:0] o2,
                      input logic rr);
    bit          any;
    int          w;
    int          idx;
    logic [3:0]  er;
    logic [31:0] a1, a2;
    @(posedge clk);
    #1;
    req_valid = v;
    req_op1   = o1;
    req_op2   = o2;
    rsp_ready = rr;
    @(negedge clk);
    chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, m_full});
    chk("op_count", {16'b0, op_count}, 32'(m_cnt));
    any = 0;
    w   = 0;
    for (int k = 0; k < 4; k++) begin
      idx = (m_ptr + k) % 4;
      if (!any && v[2'(idx)]) begin
        any = 1;
        w   = idx;
      end
    end
    a1 = any ? o1[32*w +: 32] : 32'h0;
    a2 = any ? o2[32*w +: 32] : 32'h0;
    er = (any && (!m_full || rr)) ? 4'(1 << w) : 4'b0;
    chk("req_ready", {28'b0, req_ready}, {28'b0, er});
    chk("add_op1", add_op1, a1);
    chk("add_op2", add_op2, a2);
    last_gnt = -1;
    if (er != 4'b0) begin
      exp_q.push_back('{id: 2'(w), data: fadd(a1, a2)});
      m_full   = 1;
      m_ptr    = (w + 1) % 4;
      m_cnt    = (m_cnt + 1) % 65536;
      last_gnt = w;
    end else if (m_full && rr) begin
      m_full = 0;
    end
  endtask

  // Monitor: every response consumed by the sink is checked against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", {31'b0, rsp_valid}, 32'h0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_id", {30'b0, rsp_id}, {30'b0, e.id});
          chk("rsp_data", rsp_data, e.data);
        end
      end
    end
  end

  initial begin
    int order0[5];
    int order5[3];
    order0 = '{0, 1, 2, 3, 0};
    order5 = '{2, 0, 2};

    rst_n = 1'b0;
    req_valid = 4'b0;
    req_op1 = '0;
    req_op2 = '0;
    rsp_ready = 1'b0;
    #1;
    chk("rst_valid", {31'b0, rsp_valid}, 32'h0);
    chk("rst_data", rsp_data, 32'h0);
    chk("rst_id", {30'b0, rsp_id}, 32'h0);
    chk("rst_count", {16'b0, op_count}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single request 1.0 + 2.0
    step(4'b0001, {96'b0, 32'h3F800000}, {96'b0, 32'h40000000}, 1'b1);
    chk("t1_ready", {28'b0, req_ready}, 32'h1);
    step(4'b0000, '0, '0, 1'b1);
    chk("t1_valid", {31'b0, rsp_valid}, 32'h1);
    chk("t1_id", {30'b0, rsp_id}, 32'h0);
    chk("t1_data", rsp_data, 32'h40400000);
    chk("t1_count", {16'b0, op_count}, 32'h1);

    // Round-robin over all four from pointer 0
    step(4'b1000, bcast(rnd_f()), bcast(rnd_f()), 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, {rnd_f(), rnd_f(), rnd_f(), rnd_f()},
           {rnd_f(), rnd_f(), rnd_f(), rnd_f()}, 1'b1);
      chk("t2_order", 32'(last_gnt), 32'(order0[i]));
    end

    // Backpressure for 10 cycles, then resume
    step(4'b1111, bcast(rnd_f()), bcast(rnd_f()), 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(4'b1111, bcast(rnd_f()), bcast(rnd_f()), 1'b0);
      chk("t3_stall", {28'b0, req_ready}, 32'h0);
      chk("t3_hold_data", rsp_data, exp_q[0].data);
      chk("t3_hold_id", {30'b0, rsp_id}, {30'b0, exp_q[0].id});
    end
    step(4'b1111, bcast(rnd_f()), bcast(rnd_f()), 1'b1);
    chk("t3_resume", {31'b0, req_ready != 4'b0}, 32'h1);

    // Asynchronous reset while a response is pending
    step(4'b0001, bcast(rnd_f()), bcast(rnd_f()), 1'b1);
    @(posedge clk);
    #2;
    chk("t4_pre_valid", {31'b0, rsp_valid}, 32'h1);
    rst_n = 1'b0;
    req_valid = 4'b0;
    #1;
    chk("t4_valid", {31'b0, rsp_valid}, 32'h0);
    chk("t4_data", rsp_data, 32'h0);
    chk("t4_count", {16'b0, op_count}, 32'h0);
    exp_q.delete();
    m_full = 0;
    m_ptr  = 0;
    m_cnt  = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step(4'b1111, bcast(rnd_f()), bcast(rnd_f()), 1'b1);
    chk("t4_first_gnt", 32'(last_gnt), 32'h0);

    // Sparse pattern from pointer 2
    step(4'b0010, bcast(rnd_f()), bcast(rnd_f()), 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(4'b0101, {rnd_f(), rnd_f(), rnd_f(), rnd_f()},
           {rnd_f(), rnd_f(), rnd_f(), rnd_f()}, 1'b1);
      chk("t5_order", 32'(last_gnt), 32'(order5[i]));
    end

    // Randomized traffic with random sink backpressure
    for (int i = 0; i < 400; i++) begin
      step(4'($urandom_range(0, 15)), {rnd_f(), rnd_f(), rnd_f(), rnd_f()},
           {rnd_f(), rnd_f(), rnd_f(), rnd_f()}, 1'($urandom_range(0, 3) != 0));
    end

    // Counter wrap; final accept is an opposite-sign pair
    while (m_cnt != 65535) begin
      step(4'b1111, bcast(32'h3F800000), bcast(32'h40000000), 1'b1);
    end
    step(4'b1111, bcast(32'h3F800000), bcast(32'hBF800000), 1'b1);
    step(4'b0000, '0, '0, 1'b1);
    chk("t6_wrap", {16'b0, op_count}, 32'h0);
    chk("t6_zero_sum", rsp_data, 32'h00000000);

    repeat (3) step(4'b0000, '0, '0, 1'b1);
    chk("drain_empty", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
